// File: rtl/wb_trace_fifo_if.sv
// Capture and debug-stream signals of the write-back trace buffer.
// The slave modport is the buffer itself; the master modport is the datapath plus the consumer.
interface wb_trace_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 10,
    parameter int DATA_W = 32
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = 8 + PC_W + 5 + DATA_W;

    logic               cap_en;
    logic [PC_W-1:0]    cap_pc;
    logic [4:0]         cap_reg;
    logic [DATA_W-1:0]  cap_data;
    logic               m_valid;
    logic               m_ready;
    logic [ENTRY_W-1:0] m_data;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               overflow;
    logic [15:0]        drop_count;

    modport slave (
        input  cap_en, cap_pc, cap_reg, cap_data, m_ready,
        output m_valid, m_data, count, full, empty, overflow, drop_count
    );

    modport master (
        output cap_en, cap_pc, cap_reg, cap_data, m_ready,
        input  m_valid, m_data, count, full, empty, overflow, drop_count
    );
endinterface

// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: captures committed register writes with a sequence tag
// and streams them out show-ahead; overflow drops and counts instead of stalling the core.
module wb_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 10,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    wb_trace_fifo_if.slave  bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = 8 + PC_W + 5 + DATA_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic [7:0]         seq;
    logic [15:0]        drops;
    logic               ovf;

    logic is_full;
    logic is_empty;
    logic pop;
    logic push;
    logic drop;

    assign is_full  = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);
    assign pop      = !is_empty && bus.m_ready;
    assign push     = bus.cap_en && (!is_full || pop);
    assign drop     = bus.cap_en && is_full && !pop;

    // The array is deliberately left out of reset; only pointers and counters clear.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= {seq, bus.cap_pc, bus.cap_reg, bus.cap_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            seq    <= '0;
            drops  <= '0;
            ovf    <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            seq    <= '0;
            drops  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
            // seq advances on every capture, stored or not, so gaps reveal drops.
            if (bus.cap_en)
                seq <= seq + 8'd1;
            if (drop) begin
                ovf <= 1'b1;
                if (drops != 16'hFFFF)
                    drops <= drops + 16'd1;
            end
        end
    end

    assign bus.m_valid    = !is_empty;
    assign bus.m_data     = mem[rd_ptr];
    assign bus.count      = cnt;
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;
    assign bus.overflow   = ovf;
    assign bus.drop_count = drops;
endmodule
